// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//    Shared types for the instruction/data memory arbiter.
//    arb_state_t : arbiter FSM states
//    arb_port_t  : requester identity, used for round-robin bookkeeping
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACC_A,
      ACC_B,
      RESP
   } arb_state_t;

   typedef enum logic {
      PORT_A,
      PORT_B
   } arb_port_t;

endpackage

// File: rtl/arb_cmd_reg.sv
// arb_cmd_reg
//    Command register for the memory arbiter. It captures the granted
//    requester's address, write data, byte mask and operation on load.
//    The memory port is driven only from this register.
//    Ports:
//       clk, rst_n      clock, asynchronous active-low clear
//       load            capture enable (grant)
//       addr/wdata/wmask/op_write   command to capture
//       cmd_*           registered command
module arb_cmd_reg #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wmask,
   input  logic                op_write,
   output logic [ADDR_W-1:0]   cmd_addr,
   output logic [DATA_W-1:0]   cmd_wdata,
   output logic [DATA_W/8-1:0] cmd_wmask,
   output logic                cmd_write
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_addr  <= '0;
         cmd_wdata <= '0;
         cmd_wmask <= '0;
         cmd_write <= 1'b0;
      end else if (load) begin
         cmd_addr  <= addr;
         cmd_wdata <= wdata;
         cmd_wmask <= wmask;
         cmd_write <= op_write;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//    Merges the instruction port (a) and data port (b) onto a single
//    memory port with round-robin arbitration. The granted command is
//    latched, the memory strobe is held until pmem_resp, and a one-cycle
//    registered response is returned to the granted port.
//    Ports:
//       clk, rst_n                       clock, asynchronous active-low reset
//       read_a, address_a                fetch request
//       rdata_a, resp_a                  fetch response
//       read_b, write, wmask, address_b, wdata   data request
//       rdata_b, resp_b                  data response (loads and stores)
//       pmem_*                           physical memory port
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                read_a,
   input  logic [ADDR_W-1:0]   address_a,
   output logic [DATA_W-1:0]   rdata_a,
   output logic                resp_a,
   input  logic                read_b,
   input  logic                write,
   input  logic [DATA_W/8-1:0] wmask,
   input  logic [ADDR_W-1:0]   address_b,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata_b,
   output logic                resp_b,
   output logic                pmem_read,
   output logic                pmem_write,
   output logic [ADDR_W-1:0]   pmem_address,
   output logic [DATA_W-1:0]   pmem_wdata,
   output logic [DATA_W/8-1:0] pmem_wmask,
   input  logic [DATA_W-1:0]   pmem_rdata,
   input  logic                pmem_resp
);

   arb_state_t state, state_nx;
   arb_port_t  last_grant, last_grant_nx;

   logic req_a, req_b;
   logic grant_a, grant_b;
   logic in_access;

   logic [ADDR_W-1:0]   cmd_addr_in;
   logic [DATA_W-1:0]   cmd_wdata_in;
   logic [DATA_W/8-1:0] cmd_wmask_in;
   logic                cmd_write_in;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [DATA_W-1:0]   cmd_wdata;
   logic [DATA_W/8-1:0] cmd_wmask;
   logic                cmd_write;

   assign req_a = read_a;
   assign req_b = read_b | write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= PORT_A;
      end else begin
         state      <= state_nx;
         last_grant <= last_grant_nx;
      end
   end

   // A wins when it is the only requester, or on contention when B was
   // served last; otherwise any B request wins.
   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      grant_a       = 1'b0;
      grant_b       = 1'b0;
      case (state)
         IDLE: begin
            if (req_a && (!req_b || last_grant == PORT_B)) begin
               grant_a       = 1'b1;
               state_nx      = ACC_A;
               last_grant_nx = PORT_A;
            end else if (req_b) begin
               grant_b       = 1'b1;
               state_nx      = ACC_B;
               last_grant_nx = PORT_B;
            end
         end
         ACC_A, ACC_B: begin
            if (pmem_resp) state_nx = RESP;
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Fetches always read with an empty mask; write dominates read_b.
   assign cmd_addr_in  = grant_a ? address_a : address_b;
   assign cmd_wdata_in = grant_a ? '0 : wdata;
   assign cmd_wmask_in = grant_a ? '0 : wmask;
   assign cmd_write_in = grant_b & write;

   arb_cmd_reg #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_cmd_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (grant_a | grant_b),
      .addr      (cmd_addr_in),
      .wdata     (cmd_wdata_in),
      .wmask     (cmd_wmask_in),
      .op_write  (cmd_write_in),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_wmask (cmd_wmask),
      .cmd_write (cmd_write)
   );

   assign in_access    = (state == ACC_A) || (state == ACC_B);
   assign pmem_read    = in_access && !cmd_write;
   assign pmem_write   = in_access && cmd_write;
   assign pmem_address = cmd_addr;
   assign pmem_wdata   = cmd_wdata;
   assign pmem_wmask   = cmd_wmask;

   // In RESP, last_grant still identifies the port just served.
   assign resp_a = (state == RESP) && (last_grant == PORT_A);
   assign resp_b = (state == RESP) && (last_grant == PORT_B);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else if (pmem_resp) begin
         if (state == ACC_A) rdata_a <= pmem_rdata;
         if (state == ACC_B) rdata_b <= pmem_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//    Randomized bench for mem_arbiter. Requesters and memory are driven
//    with $urandom; expectations come from a transaction timeline model
//    (grant cycle, memory response cycle, round-robin choice).
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = DW / 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          read_a = 1'b0;
   logic [AW-1:0] address_a = '0;
   logic [DW-1:0] rdata_a;
   logic          resp_a;
   logic          read_b = 1'b0;
   logic          write = 1'b0;
   logic [MW-1:0] wmask = '0;
   logic [AW-1:0] address_b = '0;
   logic [DW-1:0] wdata = '0;
   logic [DW-1:0] rdata_b;
   logic          resp_b;
   logic          pmem_read;
   logic          pmem_write;
   logic [AW-1:0] pmem_address;
   logic [DW-1:0] pmem_wdata;
   logic [MW-1:0] pmem_wmask;
   logic [DW-1:0] pmem_rdata = '0;
   logic          pmem_resp = 1'b0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .read_a       (read_a),
      .address_a    (address_a),
      .rdata_a      (rdata_a),
      .resp_a       (resp_a),
      .read_b       (read_b),
      .write        (write),
      .wmask        (wmask),
      .address_b    (address_b),
      .wdata        (wdata),
      .rdata_b      (rdata_b),
      .resp_b       (resp_b),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address),
      .pmem_wdata   (pmem_wdata),
      .pmem_wmask   (pmem_wmask),
      .pmem_rdata   (pmem_rdata),
      .pmem_resp    (pmem_resp)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transaction timeline model: granted at cycle xt, memory answers at xr,
   // port response at xr+1, next grant possible from xr+2.
   bit            act = 1'b0;
   bit            xp;            // 0 = port a, 1 = port b
   int            xt, xr;
   logic [AW-1:0] x_addr;
   bit            x_write;
   logic [DW-1:0] x_wdata;
   logic [MW-1:0] x_wmask;
   logic [DW-1:0] x_mem;
   bit            last_b = 1'b0;
   int            free_at = 0;
   logic [DW-1:0] exp_rda = '0;
   logic [DW-1:0] exp_rdb = '0;
   int            age_a = 0, age_b = 0;
   bit            rst_done = 1'b0;

   task automatic check_outputs(input int c);
      bit win;
      bit rsp;
      win = act && (c >= xt + 1) && (c <= xr);
      rsp = act && (c == xr + 1);
      if (rsp) begin
         if (!xp) exp_rda = x_mem;
         else     exp_rdb = x_mem;
      end
      check_eq("pmem_read",  pmem_read,  win && !x_write);
      check_eq("pmem_write", pmem_write, win && x_write);
      check_eq("resp_a",     resp_a,     rsp && !xp);
      check_eq("resp_b",     resp_b,     rsp && xp);
      check_eq("rdata_a",    rdata_a,    exp_rda);
      check_eq("rdata_b",    rdata_b,    exp_rdb);
      if (win) begin
         check_eq("pmem_address", pmem_address, x_addr);
         if (x_write) begin
            check_eq("pmem_wdata", pmem_wdata, x_wdata);
            check_eq("pmem_wmask", pmem_wmask, x_wmask);
         end
         if (!xp) check_eq("fetch_wmask", pmem_wmask, 0);
      end
   endtask

   task automatic start_b();
      int kind;
      kind      = $urandom_range(0, 2);
      read_b    = (kind != 1);
      write     = (kind != 0);
      address_b = $urandom() & 32'hFFFF_FFFC;
      wdata     = $urandom();
      wmask     = 4'($urandom_range(0, 15));
   endtask

   initial begin
      int  g;
      bit  win;
      repeat (2) @(negedge clk);
      check_eq("rst_pmem_read",    pmem_read,    0);
      check_eq("rst_pmem_write",   pmem_write,   0);
      check_eq("rst_resp_a",       resp_a,       0);
      check_eq("rst_resp_b",       resp_b,       0);
      check_eq("rst_rdata_a",      rdata_a,      0);
      check_eq("rst_rdata_b",      rdata_b,      0);
      check_eq("rst_pmem_address", pmem_address, 0);
      check_eq("rst_pmem_wdata",   pmem_wdata,   0);
      check_eq("rst_pmem_wmask",   pmem_wmask,   0);

      // Contention straight out of reset: B must be served first.
      read_a    = 1'b1;
      address_a = 32'h60;
      read_b    = 1'b1;
      address_b = 32'h100;
      rst_n     = 1'b1;

      for (int c = 0; c < 3000; c++) begin
         if (c > 0) @(negedge clk);
         check_outputs(c);
         if (act && c == xr + 1) begin
            act     = 1'b0;
            free_at = c + 1;
         end

         if (!rst_n) begin
            rst_n   = 1'b1;
            free_at = c;
         end else if (!rst_done && c > 1500 && act && !xp && c >= xt + 1 && c <= xr) begin
            rst_n    = 1'b0;
            rst_done = 1'b1;
            #1;
            check_eq("midrst_pmem_read",    pmem_read,    0);
            check_eq("midrst_pmem_write",   pmem_write,   0);
            check_eq("midrst_resp_a",       resp_a,       0);
            check_eq("midrst_resp_b",       resp_b,       0);
            check_eq("midrst_pmem_address", pmem_address, 0);
            act       = 1'b0;
            last_b    = 1'b0;
            exp_rda   = '0;
            exp_rdb   = '0;
            pmem_resp = 1'b0;
            continue;
         end

         // Requester a
         if (resp_a) begin
            read_a = 1'b0;
         end else if (!read_a && $urandom_range(0, 2) == 0) begin
            read_a    = 1'b1;
            address_a = $urandom() & 32'hFFFF_FFFC;
         end else if (read_a && $urandom_range(0, 3) == 0) begin
            address_a = $urandom() & 32'hFFFF_FFFC;
         end
         // Requester b
         if (resp_b) begin
            read_b = 1'b0;
            write  = 1'b0;
         end else if (!(read_b || write) && $urandom_range(0, 2) == 0) begin
            start_b();
         end else if ((read_b || write) && $urandom_range(0, 3) == 0) begin
            address_b = $urandom() & 32'hFFFF_FFFC;
            wdata     = $urandom();
            wmask     = 4'($urandom_range(0, 15));
         end

         if (read_a) age_a++; else age_a = 0;
         if (read_b || write) age_b++; else age_b = 0;
         if (read_a) check_eq("wait_a", age_a > 40, 0);
         if (read_b || write) check_eq("wait_b", age_b > 40, 0);

         // Memory: answer at the chosen cycle; stray pulses only outside access.
         pmem_rdata = $urandom();
         win = act && (c >= xt + 1) && (c <= xr);
         if (act && c == xr) begin
            pmem_resp = 1'b1;
            x_mem     = pmem_rdata;
         end else if (!win && $urandom_range(0, 5) == 0) begin
            pmem_resp = 1'b1;
         end else begin
            pmem_resp = 1'b0;
         end

         // Round-robin grant decision for this cycle.
         if (!act && c >= free_at && (read_a || read_b || write)) begin
            if (read_a && (read_b || write)) g = last_b ? 0 : 1;
            else                             g = read_a ? 0 : 1;
            xp     = (g == 1);
            last_b = xp;
            act    = 1'b1;
            xt     = c;
            xr     = c + $urandom_range(1, 4);
            if (!xp) begin
               x_addr  = address_a;
               x_write = 1'b0;
               x_wdata = '0;
               x_wmask = '0;
            end else begin
               x_addr  = address_b;
               x_write = write;
               x_wdata = wdata;
               x_wmask = wmask;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
